// File: rtl/rmf_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rmf_frame_ctrl
// Brief    : Frame sequencer for the 5x5 recursive median core. Generates the
//            tick (core_ce/win_shift), flush pads, feedback init and the
//            bordered output stream. Optional macro RMF_SOF_ERR_EN adds
//            stray-sof frame abort and the sticky err_sof output.
// Revision : 1.0 - initial release
// ============================================================================
module rmf_frame_ctrl #(
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int CORE_LAT = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_valid,
   input  logic       s_sof,
   output logic       s_ready,
   output logic       win_shift,
   output logic       win_pad,
   output logic       core_ce,
   output logic       fb_init,
   input  logic [7:0] win_center,
   input  logic [7:0] core_mid,
   output logic       m_valid,
   output logic [7:0] m_data,
   output logic       m_eol,
   output logic       m_eof,
`ifdef RMF_SOF_ERR_EN
   output logic       err_sof,
`endif
   output logic       frame_done
);

   localparam int LEAD = 2 * IMG_W + 2;
   localparam int TOT  = LEAD + CORE_LAT;
   localparam int NPIX = IMG_W * IMG_H;
   localparam int PW   = $clog2(TOT + 1);
   localparam int FW   = $clog2(TOT);
   localparam int IW   = $clog2(NPIX);
   localparam int CW   = $clog2(IMG_W);
   localparam int RW   = $clog2(IMG_H);

   localparam logic [PW-1:0] PRE_LEAD = PW'(LEAD);
   localparam logic [PW-1:0] PRE_TOT  = PW'(TOT);
   localparam logic [FW-1:0] FL_LAST  = FW'(TOT - 1);
   localparam logic [IW-1:0] IN_LAST  = IW'(NPIX - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [CW-1:0] COL_HI   = CW'(IMG_W - 3);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [RW-1:0] ROW_HI   = RW'(IMG_H - 3);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t        state_q;
   logic          rdy_q;
   logic [IW-1:0] in_cnt_q;
   logic [PW-1:0] pre_cnt_q;
   logic [FW-1:0] fl_cnt_q;
   logic [CW-1:0] c_col_q, c_col_d, o_col_q, o_col_d;
   logic [RW-1:0] c_row_q, c_row_d, o_row_q, o_row_d;
   logic [7:0]    dly_q [CORE_LAT];
   logic          m_valid_q, m_eol_q, m_eof_q, frame_done_q;
   logic [7:0]    m_data_q;

   logic accept, sof_abort, frame_start, tick, c_en, o_en, border;

   assign s_ready = rdy_q & (state_q != ST_FLUSH);
   assign accept  = s_valid & s_ready;

`ifdef RMF_SOF_ERR_EN
   logic err_q;
   assign sof_abort = s_valid & s_sof & ((state_q == ST_RUN) | (state_q == ST_FLUSH));
   assign err_sof   = err_q;
`else
   assign sof_abort = 1'b0;
`endif

   // A restart tick is pixel 0 of the new frame, so it never advances the centre/output counters.
   assign frame_start = (accept & s_sof & (state_q == ST_IDLE)) | sof_abort;
   assign tick        = frame_start | (accept & (state_q == ST_RUN)) | (state_q == ST_FLUSH);
   assign c_en        = tick & ~frame_start & (pre_cnt_q >= PRE_LEAD);
   assign o_en        = tick & ~frame_start & (pre_cnt_q == PRE_TOT);

   assign win_shift = tick;
   assign core_ce   = tick;
   assign win_pad   = (state_q == ST_FLUSH) & ~sof_abort;
   assign fb_init   = c_en & (c_col_q == COL_TWO) & (c_row_q >= ROW_TWO) & (c_row_q <= ROW_HI);

   assign border = (o_row_q < ROW_TWO) | (o_row_q > ROW_HI) |
                   (o_col_q < COL_TWO) | (o_col_q > COL_HI);

   always_comb begin
      c_col_d = c_col_q + CW'(1);
      c_row_d = c_row_q;
      if (c_col_q == COL_LAST) begin
         c_col_d = '0;
         c_row_d = (c_row_q == ROW_LAST) ? '0 : c_row_q + RW'(1);
      end
      o_col_d = o_col_q + CW'(1);
      o_row_d = o_row_q;
      if (o_col_q == COL_LAST) begin
         o_col_d = '0;
         o_row_d = (o_row_q == ROW_LAST) ? '0 : o_row_q + RW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CORE_LAT; i++) dly_q[i] <= '0;
      end else if (tick) begin
         dly_q[0] <= win_center;
         for (int i = 1; i < CORE_LAT; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rdy_q        <= 1'b0;
         in_cnt_q     <= '0;
         pre_cnt_q    <= '0;
         fl_cnt_q     <= '0;
         c_col_q      <= '0;
         c_row_q      <= '0;
         o_col_q      <= '0;
         o_row_q      <= '0;
         m_valid_q    <= 1'b0;
         m_data_q     <= '0;
         m_eol_q      <= 1'b0;
         m_eof_q      <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef RMF_SOF_ERR_EN
         err_q        <= 1'b0;
`endif
      end else begin
         rdy_q        <= 1'b1;
         frame_done_q <= 1'b0;
         m_valid_q    <= o_en;
         m_eol_q      <= o_en & (o_col_q == COL_LAST);
         m_eof_q      <= o_en & (o_col_q == COL_LAST) & (o_row_q == ROW_LAST);
         if (o_en) begin
            m_data_q <= border ? dly_q[CORE_LAT-1] : core_mid;
            o_col_q  <= o_col_d;
            o_row_q  <= o_row_d;
         end
         if (c_en) begin
            c_col_q <= c_col_d;
            c_row_q <= c_row_d;
         end
         if (tick && (pre_cnt_q != PRE_TOT)) pre_cnt_q <= pre_cnt_q + PW'(1);
`ifdef RMF_SOF_ERR_EN
         if (sof_abort) err_q <= 1'b1;
`endif
         if (frame_start) begin
            state_q   <= ST_RUN;
            in_cnt_q  <= IW'(1);
            pre_cnt_q <= PW'(1);
            fl_cnt_q  <= '0;
            c_col_q   <= '0;
            c_row_q   <= '0;
            o_col_q   <= '0;
            o_row_q   <= '0;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (accept) begin
                     in_cnt_q <= in_cnt_q + IW'(1);
                     if (in_cnt_q == IN_LAST) begin
                        state_q  <= ST_FLUSH;
                        fl_cnt_q <= '0;
                     end
                  end
               end
               ST_FLUSH: begin
                  if (fl_cnt_q == FL_LAST) begin
                     state_q      <= ST_IDLE;
                     frame_done_q <= 1'b1;
                     in_cnt_q     <= '0;
                     pre_cnt_q    <= '0;
                     fl_cnt_q     <= '0;
                     c_col_q      <= '0;
                     c_row_q      <= '0;
                     o_col_q      <= '0;
                     o_row_q      <= '0;
                  end else begin
                     fl_cnt_q <= fl_cnt_q + FW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_eol      = m_eol_q;
   assign m_eof      = m_eof_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_rmf_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rmf_frame_ctrl
// Brief    : Directed scoreboard bench for rmf_frame_ctrl (8x8 image, latency 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rmf_frame_ctrl;

   localparam int W    = 8;
   localparam int H    = 8;
   localparam int LAT  = 3;
   localparam int LEAD = 2 * W + 2;
   localparam int TOT  = LEAD + LAT;
   localparam int NPIX = W * H;

   typedef struct packed {
      logic [7:0] d;
      logic       eol;
      logic       eof;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_valid = 1'b0;
   logic       s_sof = 1'b0;
   logic [7:0] win_center = '0;
   logic [7:0] core_mid = '0;
   logic       s_ready, win_shift, win_pad, core_ce, fb_init;
   logic       m_valid, m_eol, m_eof, frame_done;
   logic [7:0] m_data;
`ifdef RMF_SOF_ERR_EN
   logic       err_sof;
`endif

   rmf_frame_ctrl #(.IMG_W(W), .IMG_H(H), .CORE_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_sof(s_sof), .s_ready(s_ready),
      .win_shift(win_shift), .win_pad(win_pad), .core_ce(core_ce), .fb_init(fb_init),
      .win_center(win_center), .core_mid(core_mid), .m_valid(m_valid), .m_data(m_data),
      .m_eol(m_eol), .m_eof(m_eof),
`ifdef RMF_SOF_ERR_EN
      .err_sof(err_sof),
`endif
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int   n_assert = 0;
   int   n_fail = 0;
   int   mode = 0;     // 0 idle, 1 run, 2 flush
   int   pin = 0;
   int   fcnt = 0;
   int   tk = 0;
   bit   cmode = 1'b0;
   int   out_obs, fb_obs, fd_obs, fl_obs, aa_obs;
   exp_t sbq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] img(input int p);
      return cmode ? 8'h40 : 8'(p * 5 + 1);
   endfunction

   function automatic logic [7:0] mid(input int j);
      return cmode ? 8'hAA : (8'(j) ^ 8'hC3);
   endfunction

   function automatic bit bord(input int j);
      int r, c;
      r = j / W;
      c = j % W;
      return (r < 2) || (r > H - 3) || (c < 2) || (c > W - 3);
   endfunction

   // One clock: drive at negedge, check combinational strobes, then registered outputs after posedge.
   task automatic cyc(input logic v, input logic sof);
      int   smode, ci, j;
      bit   ab, et, epad, efb, push, fd;
      exp_t e, got;
      @(negedge clk);
      s_valid = v;
      s_sof   = sof;
      smode   = mode;
      ab      = 1'b0;
`ifdef RMF_SOF_ERR_EN
      ab = (mode != 0) && v && sof;
      if (ab) begin
         mode = 0; tk = 0; pin = 0; fcnt = 0;
         out_obs = 0; fb_obs = 0; aa_obs = 0;
      end
`endif
      et   = (mode == 0 && v && sof) || (mode == 1 && v) || (mode == 2);
      epad = (mode == 2);
      win_center = (tk >= LEAD && tk - LEAD < NPIX) ? img(tk - LEAD) : 8'h5A;
      core_mid   = (tk >= TOT && tk - TOT < NPIX) ? mid(tk - TOT) : 8'h00;
      ci   = tk - LEAD;
      efb  = et && (tk >= LEAD) && (ci % W == 2) && (ci / W >= 2) && (ci / W <= H - 3);
      push = et && (tk >= TOT);
      if (push) begin
         j     = tk - TOT;
         e.d   = bord(j) ? img(j) : mid(j);
         e.eol = (j % W == W - 1);
         e.eof = (j == NPIX - 1);
         sbq.push_back(e);
      end
      #1;
      chk("core_ce", core_ce, et);
      chk("win_shift", win_shift, et);
      chk("win_pad", win_pad, epad);
      chk("fb_init", fb_init, efb);
      chk("s_ready", s_ready, (smode != 2));
      if (fb_init) fb_obs++;
      if (!s_ready) fl_obs++;
      fd = 1'b0;
      if (et) begin
         if (mode == 0) begin
            mode = 1; pin = 1;
         end else if (mode == 1) begin
            pin++;
            if (pin == NPIX) begin mode = 2; fcnt = 0; end
         end else begin
            fcnt++;
            if (fcnt == TOT) begin mode = 0; fd = 1'b1; end
         end
         tk = fd ? 0 : tk + 1;
      end
      @(posedge clk);
      #1;
      chk("m_valid", m_valid, push);
      chk("frame_done", frame_done, fd);
      if (m_valid) begin
         out_obs++;
         chk("sb_nonempty", (sbq.size() != 0), 1);
         if (sbq.size() != 0) begin
            got = sbq.pop_front();
            chk("m_data", m_data, got.d);
            chk("m_eol", m_eol, got.eol);
            chk("m_eof", m_eof, got.eof);
            if (m_data == 8'hAA) aa_obs++;
         end
      end
      if (frame_done) fd_obs++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_sof   = 1'b0;
      #1;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_core_ce", core_ce, 0);
      chk("rst_m_data", m_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mode = 0; tk = 0; pin = 0; fcnt = 0;
      sbq.delete();
      @(posedge clk);
      #1;
      chk("rel_s_ready", s_ready, 1);
      chk("rel_frame_done", frame_done, 0);
   endtask

   task automatic run_frame(input bit bub, input int abort_at, input int rst_at);
      int   guard;
      logic v, sof;
      out_obs = 0; fb_obs = 0; fd_obs = 0; fl_obs = 0; aa_obs = 0;
      cyc(1'b1, 1'b1);
      guard = 0;
      while (mode != 0 && guard < 3000) begin
         if (mode == 1) begin
            v   = bub ? 1'($urandom_range(0, 1)) : 1'b1;
            sof = (abort_at >= 0) && (pin == abort_at) && v;
            if (sof) abort_at = -1;
            cyc(v, sof);
         end else if (rst_at >= 0 && fcnt == rst_at) begin
            do_reset();
            chk("midflush_no_done", fd_obs, 0);
            return;
         end else begin
            cyc(1'b0, 1'b0);
         end
         guard++;
      end
      chk("frame_timeout", (guard < 3000), 1);
      chk("out_count", out_obs, NPIX);
      chk("fb_count", fb_obs, 4);
      chk("done_count", fd_obs, 1);
      chk("flush_cycles", fl_obs, TOT);
      chk("sb_drain", sbq.size(), 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_s_ready", s_ready, 0);
      chk("reset_m_valid", m_valid, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_m_eof", m_eof, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("release_s_ready", s_ready, 1);

      // Stray pixels before any sof must be swallowed.
      out_obs = 0;
      repeat (5) cyc(1'b1, 1'b0);
      chk("idle_no_output", out_obs, 0);

      cmode = 1'b0;
      run_frame(1'b0, -1, -1);
`ifdef RMF_SOF_ERR_EN
      chk("err_sof_clear", err_sof, 0);
`endif

      cmode = 1'b1;
      run_frame(1'b0, -1, -1);
      chk("interior_aa", aa_obs, 16);
      cmode = 1'b0;

      run_frame(1'b1, -1, -1);

`ifdef RMF_SOF_ERR_EN
      run_frame(1'b0, 30, -1);
      chk("err_sof_set", err_sof, 1);
`endif

      run_frame(1'b0, -1, 5);
      fd_obs = 0;
      repeat (4) cyc(1'b0, 1'b0);
      chk("post_reset_idle", fd_obs, 0);
`ifdef RMF_SOF_ERR_EN
      chk("err_sof_reset", err_sof, 0);
`endif
      run_frame(1'b0, -1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
